// File: rtl/dcache_bus_router.sv
// Routes data-cache line fills/writebacks and single-word peripheral accesses onto a burst bus.
// Define ROUTER_WRAP_BURST_EN for critical-word-first WRAP line bursts; INCR from word 0 otherwise.
module dcache_bus_router (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  biu_adr_i,
  input  logic         biu_cyc_i,
  input  logic         biu_stb_i,
  input  logic         biu_we_i,
  input  logic         biu_cab_i,
  input  logic [3:0]   biu_sel_i,
  output logic [31:0]  biu_dat_o,
  output logic         bus_rdy,
  inout  wire  [255:0] bus_data,
  input  logic         peripheral_access,
  input  logic         freeze,
  output logic [31:0]  ADDR,
  output logic [1:0]   BURST,
  output logic         REQ,
  output logic         WRB,
  output logic [31:0]  WDATA,
  output logic [3:0]   BSTROBE,
  input  logic [31:0]  RDATA,
  input  logic         ACK,
  input  logic         STALL
);

`ifdef ROUTER_WRAP_BURST_EN
  localparam logic [1:0] LineBurst = 2'b10;
  localparam logic [2:0] WrapMask  = 3'b111;
`else
  localparam logic [1:0] LineBurst = 2'b01;
  localparam logic [2:0] WrapMask  = 3'b000;
`endif

  typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

  state_e        state_q, state_d;
  logic [31:0]   adr_q, adr_d;
  logic          we_q, we_d;
  logic [3:0]    sel_q, sel_d;
  logic          line_mode_q, line_mode_d;
  logic [2:0]    beat_q, beat_d;
  logic [255:0]  line_q, line_d;
  logic [31:0]   dat_q, dat_d;
  logic [31:0]   addr_q, addr_d;
  logic [1:0]    burst_q, burst_d;
  logic          req_q, req_d;
  logic          wrb_q, wrb_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    strobe_q, strobe_d;

  logic          entry_line;
  logic [2:0]    entry_idx;
  logic [2:0]    cur_idx;
  logic [2:0]    nxt_idx;
  logic          beat_done;

  // Word index of the first beat; WrapMask selects critical-word-first in line mode.
  assign entry_line = biu_cab_i & ~peripheral_access;
  assign entry_idx  = entry_line ? (biu_adr_i[4:2] & WrapMask) : biu_adr_i[4:2];
  assign cur_idx    = line_mode_q ? ((adr_q[4:2] & WrapMask) + beat_q) : adr_q[4:2];
  assign nxt_idx    = cur_idx + 3'd1;
  assign beat_done  = ACK & ~STALL;

  always_comb begin
    state_d     = state_q;
    adr_d       = adr_q;
    we_d        = we_q;
    sel_d       = sel_q;
    line_mode_d = line_mode_q;
    beat_d      = beat_q;
    line_d      = line_q;
    dat_d       = dat_q;
    addr_d      = addr_q;
    burst_d     = burst_q;
    req_d       = req_q;
    wrb_d       = wrb_q;
    wdata_d     = wdata_q;
    strobe_d    = strobe_q;
    unique case (state_q)
      StIdle: begin
        if (biu_cyc_i & biu_stb_i & ~freeze) begin
          state_d     = StXfer;
          adr_d       = biu_adr_i;
          we_d        = biu_we_i;
          sel_d       = biu_sel_i;
          line_mode_d = entry_line;
          beat_d      = 3'd0;
          req_d       = 1'b1;
          wrb_d       = biu_we_i;
          addr_d      = entry_line ? {biu_adr_i[31:5], entry_idx, 2'b00} : biu_adr_i;
          burst_d     = entry_line ? LineBurst : 2'b00;
          strobe_d    = entry_line ? 4'hF : biu_sel_i;
          wdata_d     = biu_we_i ? bus_data[{entry_idx, 5'b0} +: 32] : 32'h0;
        end
      end
      StXfer: begin
        if (beat_done) begin
          if (!we_q) begin
            line_d[{cur_idx, 5'b0} +: 32] = RDATA;
            if (!line_mode_q) dat_d = RDATA;
          end
          if (!line_mode_q || beat_q == 3'd7) begin
            state_d = StDone;
            req_d   = 1'b0;
            wrb_d   = 1'b0;
            burst_d = 2'b00;
          end else begin
            beat_d = beat_q + 3'd1;
            addr_d = {adr_q[31:5], nxt_idx, 2'b00};
            if (we_q) wdata_d = bus_data[{nxt_idx, 5'b0} +: 32];
          end
        end
      end
      StDone: begin
        // Requiring cyc low before IDLE keeps a held request from retriggering.
        if (!biu_cyc_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      adr_q       <= 32'h0;
      we_q        <= 1'b0;
      sel_q       <= 4'h0;
      line_mode_q <= 1'b0;
      beat_q      <= 3'd0;
      line_q      <= 256'h0;
      dat_q       <= 32'h0;
      addr_q      <= 32'h0;
      burst_q     <= 2'b00;
      req_q       <= 1'b0;
      wrb_q       <= 1'b0;
      wdata_q     <= 32'h0;
      strobe_q    <= 4'h0;
    end else begin
      state_q     <= state_d;
      adr_q       <= adr_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      line_mode_q <= line_mode_d;
      beat_q      <= beat_d;
      line_q      <= line_d;
      dat_q       <= dat_d;
      addr_q      <= addr_d;
      burst_q     <= burst_d;
      req_q       <= req_d;
      wrb_q       <= wrb_d;
      wdata_q     <= wdata_d;
      strobe_q    <= strobe_d;
    end
  end

  assign ADDR      = addr_q;
  assign BURST     = burst_q;
  assign REQ       = req_q;
  assign WRB       = wrb_q;
  assign WDATA     = wdata_q;
  assign BSTROBE   = strobe_q;
  assign biu_dat_o = dat_q;
  assign bus_rdy   = (state_q == StDone);
  assign bus_data  = (state_q != StIdle && !we_q) ? line_q : {256{1'bz}};

endmodule

// File: tb/tb_dcache_bus_router.sv
// Scoreboard bench for dcache_bus_router: randomized and directed transfers against a
// word-level reference model; follows ROUTER_WRAP_BURST_EN when defined.
module tb_dcache_bus_router;

`ifdef ROUTER_WRAP_BURST_EN
  localparam bit Wrap = 1'b1;
`else
  localparam bit Wrap = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  biu_adr_i;
  logic         biu_cyc_i, biu_stb_i, biu_we_i, biu_cab_i;
  logic [3:0]   biu_sel_i;
  logic [31:0]  biu_dat_o;
  logic         bus_rdy;
  wire  [255:0] bus_data;
  logic         peripheral_access, freeze;
  logic [31:0]  ADDR;
  logic [1:0]   BURST;
  logic         REQ, WRB;
  logic [31:0]  WDATA;
  logic [3:0]   BSTROBE;
  logic [31:0]  RDATA;
  logic         ACK, STALL;

  logic [255:0] tb_bus;
  logic         tb_drv;
  assign bus_data = tb_drv ? tb_bus : {256{1'bz}};

  always #5 clk = ~clk;

  dcache_bus_router dut (
    .clk               (clk),
    .reset             (reset),
    .biu_adr_i         (biu_adr_i),
    .biu_cyc_i         (biu_cyc_i),
    .biu_stb_i         (biu_stb_i),
    .biu_we_i          (biu_we_i),
    .biu_cab_i         (biu_cab_i),
    .biu_sel_i         (biu_sel_i),
    .biu_dat_o         (biu_dat_o),
    .bus_rdy           (bus_rdy),
    .bus_data          (bus_data),
    .peripheral_access (peripheral_access),
    .freeze            (freeze),
    .ADDR              (ADDR),
    .BURST             (BURST),
    .REQ               (REQ),
    .WRB               (WRB),
    .WDATA             (WDATA),
    .BSTROBE           (BSTROBE),
    .RDATA             (RDATA),
    .ACK               (ACK),
    .STALL             (STALL)
  );

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  burst;
    logic        wrb;
    logic [3:0]  strobe;
    logic [31:0] wdata;
    logic        last;
  } beat_t;

  typedef struct {
    logic         rd;
    logic [31:0]  dat;
    logic [255:0] line;
  } res_t;

  beat_t       beat_q[$];
  res_t        res_q[$];
  logic [31:0] rd_q[$];

  logic [31:0] mdl_line[8];
  logic [31:0] mdl_dat;

  int vectors     = 0;
  int miscompares = 0;
  int slave_mode  = 1;
  int txn_beats   = 0;
  int stalls_left = 0;
  bit exp_rdy     = 1'b0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave: accepts a beat when REQ & ACK & ~STALL, serving queued RDATA in order.
  always @(posedge clk) begin
    if (!reset && REQ && ACK && !STALL && rd_q.size() > 0) void'(rd_q.pop_front());
    if (!reset && REQ && STALL && slave_mode == 2 && stalls_left > 0) stalls_left--;
    #1;
    case (slave_mode)
      0: begin
        ACK   = ($urandom_range(0, 9) < 6);
        STALL = ($urandom_range(0, 3) == 0);
      end
      2: begin
        ACK   = 1'b1;
        STALL = ((txn_beats - rd_q.size()) == 3) && (stalls_left > 0);
      end
      default: begin
        ACK   = 1'b1;
        STALL = 1'b0;
      end
    endcase
    RDATA = (rd_q.size() > 0) ? rd_q[0] : 32'h0;
  end

  // Monitor: checks every REQ cycle against the head beat and the result at bus_rdy.
  always @(negedge clk) begin
    beat_t e;
    res_t  r;
    if (!reset) begin
      if (exp_rdy) begin
        exp_rdy = 1'b0;
        check("rdy_after_last", bus_rdy, 1'b1);
        check("done_req_wrb_burst", {REQ, WRB, BURST}, 4'h0);
        if (res_q.size() > 0) begin
          r = res_q.pop_front();
          check("biu_dat_o", biu_dat_o, r.dat);
          if (r.rd) check("read_line", bus_data, r.line);
        end
      end else if (bus_rdy) begin
        check("held_done_no_req", REQ, 1'b0);
      end
      if (REQ) begin
        if (beat_q.size() == 0) begin
          check("unexpected_req", REQ, 1'b0);
        end else begin
          e = beat_q[0];
          check("addr", ADDR, e.addr);
          check("burst", BURST, e.burst);
          check("wrb", WRB, e.wrb);
          check("bstrobe", BSTROBE, e.strobe);
          if (e.wrb) check("wdata", WDATA, e.wdata);
          if (ACK && !STALL) begin
            if (e.last) exp_rdy = 1'b1;
            void'(beat_q.pop_front());
          end
        end
      end
    end
  end

  // rmode: 0 random data, 1 RDATA=0xA0+beat / write words=k, 2 RDATA=0x12345678.
  task automatic issue(input logic [31:0] adr, input logic we, input logic cab,
                       input logic periph, input logic [3:0] sel, input int rmode);
    bit          line;
    int          n;
    int          widx;
    logic [31:0] wr[8];
    logic [31:0] rdat;
    beat_t       b;
    res_t        r;
    line = cab && !periph;
    n    = line ? 8 : 1;
    for (int k = 0; k < 8; k++) begin
      wr[k] = (rmode == 1) ? 32'(k) : $urandom;
      tb_bus[32*k +: 32] = wr[k];
    end
    tb_drv = we;
    for (int i = 0; i < n; i++) begin
      widx = line ? (((Wrap ? int'(adr[4:2]) : 0) + i) % 8) : int'(adr[4:2]);
      rdat = (rmode == 1) ? 32'hA0 + 32'(i) : (rmode == 2) ? 32'h1234_5678 : $urandom;
      rd_q.push_back(rdat);
      if (!we) begin
        mdl_line[widx] = rdat;
        if (!line) mdl_dat = rdat;
      end
      b.addr   = line ? ({adr[31:5], 5'b0} + 32'(widx * 4)) : adr;
      b.burst  = line ? (Wrap ? 2'b10 : 2'b01) : 2'b00;
      b.wrb    = we;
      b.strobe = line ? 4'hF : sel;
      b.wdata  = wr[widx];
      b.last   = (i == n - 1);
      beat_q.push_back(b);
    end
    r.rd  = !we;
    r.dat = mdl_dat;
    for (int k = 0; k < 8; k++) r.line[32*k +: 32] = mdl_line[k];
    res_q.push_back(r);
    txn_beats         = n;
    biu_adr_i         = adr;
    biu_we_i          = we;
    biu_cab_i         = cab;
    peripheral_access = periph;
    biu_sel_i         = sel;
    biu_cyc_i         = 1'b1;
    biu_stb_i         = 1'b1;
  endtask

  task automatic run(input logic [31:0] adr, input logic we, input logic cab, input logic periph,
                     input logic [3:0] sel, input int rmode, input int fcyc, input int hold);
    int cnt;
    issue(adr, we, cab, periph, sel, rmode);
    if (fcyc > 0) begin
      freeze = 1'b1;
      repeat (fcyc) begin
        @(negedge clk);
        check("frozen_no_req", REQ, 1'b0);
      end
      @(posedge clk);
      #1 freeze = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    check("req_rise", REQ, 1'b1);
    // Request-side inputs are ignored once the transfer is under way.
    #1;
    biu_adr_i         = $urandom;
    biu_we_i          = 1'($urandom);
    biu_sel_i         = 4'($urandom);
    biu_cab_i         = 1'($urandom);
    peripheral_access = 1'($urandom);
    freeze            = 1'($urandom);
    cnt = 0;
    while (!bus_rdy && cnt < 400) begin
      @(negedge clk);
      cnt++;
    end
    if (!bus_rdy) check("rdy_timeout", bus_rdy, 1'b1);
    repeat (hold) @(negedge clk);
    @(posedge clk);
    #1;
    biu_cyc_i = 1'b0;
    biu_stb_i = 1'b0;
    freeze    = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_released(input string name);
    logic [255:0] pat;
    pat    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    tb_bus = pat;
    tb_drv = 1'b1;
    #1 check(name, bus_data, pat);
    tb_drv = 1'b0;
  endtask

  initial begin
    int cnt;
    reset = 1'b1;
    biu_adr_i = 32'h0; biu_cyc_i = 1'b0; biu_stb_i = 1'b0; biu_we_i = 1'b0;
    biu_cab_i = 1'b0; biu_sel_i = 4'h0; peripheral_access = 1'b0; freeze = 1'b0;
    ACK = 1'b0; STALL = 1'b0; RDATA = 32'h0; tb_drv = 1'b0; tb_bus = 256'h0;
    for (int k = 0; k < 8; k++) mdl_line[k] = 32'h0;
    mdl_dat = 32'h0;

    repeat (3) @(negedge clk);
    check("rst_req_wrb_burst", {REQ, WRB, BURST}, 4'h0);
    check("rst_addr", ADDR, 32'h0);
    check("rst_wdata", WDATA, 32'h0);
    check("rst_bstrobe", BSTROBE, 4'h0);
    check("rst_dat", biu_dat_o, 32'h0);
    check("rst_rdy", bus_rdy, 1'b0);
    check_released("rst_bus_release");
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;

    // Line read, RDATA = 0xA0 + beat
    slave_mode = 1;
    run(32'h0000_1044, 1'b0, 1'b1, 1'b0, 4'hF, 1, 0, 2);
    check_released("idle_bus_release");

    // Line write, words = k, two stall cycles at beat 3
    slave_mode  = 2;
    stalls_left = 2;
    run(32'h0000_2000, 1'b1, 1'b1, 1'b0, 4'hF, 1, 0, 0);

    // Peripheral single-word read
    slave_mode = 1;
    run(32'h4000_0008, 1'b0, 1'b1, 1'b1, 4'b0011, 2, 0, 1);

    // Request held off by freeze
    run(32'h0000_3010, 1'b1, 1'b0, 1'b0, 4'b1100, 0, 3, 0);

    // Line read at 0x1058 (critical-word-first when wrapping)
    run(32'h0000_1058, 1'b0, 1'b1, 1'b0, 4'hF, 0, 0, 0);

    // Reset in the middle of a line read
    issue(32'h2000_0310, 1'b0, 1'b1, 1'b0, 4'hF, 0);
    cnt = 0;
    while ((txn_beats - rd_q.size()) < 4 && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    if ((txn_beats - rd_q.size()) < 4) check("mid_reset_reach_beat4", 1'b0, 1'b1);
    reset = 1'b1;
    #1;
    check("mid_rst_req", REQ, 1'b0);
    check("mid_rst_rdy", bus_rdy, 1'b0);
    check("mid_rst_dat", biu_dat_o, 32'h0);
    check_released("mid_rst_bus_release");
    beat_q.delete();
    res_q.delete();
    rd_q.delete();
    exp_rdy = 1'b0;
    for (int k = 0; k < 8; k++) mdl_line[k] = 32'h0;
    mdl_dat   = 32'h0;
    biu_cyc_i = 1'b0;
    biu_stb_i = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    // Single read after reset exposes the cleared line register in the other words
    run(32'h0000_0104, 1'b0, 1'b0, 1'b0, 4'hF, 0, 0, 0);
    run(32'h2000_0310, 1'b0, 1'b1, 1'b0, 4'hF, 0, 0, 0);

    // Randomized traffic with a stalling slave
    slave_mode = 0;
    for (int t = 0; t < 40; t++) begin
      run($urandom, 1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
          4'($urandom), 0, ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0,
          $urandom_range(0, 3));
    end

    repeat (3) @(negedge clk);
    check("no_leftover_beats", 32'(beat_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors %0d miscompares",
             vectors, miscompares);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dcache_bus_router.md
DCACHE_BUS_ROUTER -- requirements
Module: dcache_bus_router

Interface
REQ-001 clk  in  1  single system clock; all state updates on its rising edge.
REQ-002 reset  in  1  asynchronous, active-high reset.
REQ-003 biu_adr_i  in  32  byte address of the cache/peripheral request.
REQ-004 biu_cyc_i, biu_stb_i  in  1 each  request valid; both high = request present.
REQ-005 biu_we_i  in  1  1 = write, 0 = read.
REQ-006 biu_cab_i  in  1  1 = line (burst) access permitted.
REQ-007 biu_sel_i  in  4  byte lanes for single-word access.
REQ-008 biu_dat_o  out  32  read data of a single-word access.
REQ-009 bus_rdy  out  1  transaction complete.
REQ-010 bus_data  inout  256  8-word cache line; word k = bits [32k+31:32k]; the cache drives it for writes, this block drives it for reads.
REQ-011 peripheral_access  in  1  1 = single-word uncached access.
REQ-012 freeze  in  1  1 = bus owned elsewhere; no new transaction may start.
REQ-013 ADDR out 32; BURST out 2 (00 single, 01 INCR, 10 WRAP, 11 unused); REQ out 1; WRB out 1 (1 = write); WDATA out 32; BSTROBE out 4.
REQ-014 RDATA in 32; ACK in 1 (one beat done); STALL in 1 (slave not accepting; hold outputs).

Function
REQ-015 FSM states: IDLE, XFER, DONE.
REQ-016 IDLE->XFER when biu_cyc_i & biu_stb_i & ~freeze; request fields are latched on that edge.
REQ-017 Mode is latched at XFER entry:
- Line mode when biu_cab_i=1 and peripheral_access=0.
- Single mode otherwise.
REQ-018 Line mode: 8 beats, BSTROBE=4'hF, BURST=01, start address {adr[31:5],5'b0}, ADDR advances by 4 after each ACKed beat.
REQ-019 Single mode: 1 beat, BURST=00, ADDR=latched biu_adr_i, BSTROBE=latched biu_sel_i.
REQ-020 REQ=1 throughout XFER.
- While STALL=1 or ACK=0, ADDR/WDATA/BSTROBE hold.
- The beat counter advances only on ACK=1 & STALL=0.
REQ-021 Writes: WRB=1.
- Line WDATA = bus_data word[beat].
- Single WDATA = bus_data word[adr[4:2]].
REQ-022 Reads: each ACKed beat captures RDATA.
- Line mode: into line register word[beat].
- Single mode: into biu_dat_o and line-register word[adr[4:2]].
REQ-023 Last ACKed beat -> DONE; REQ, WRB, BURST drop to 0 on that edge.
REQ-024 DONE: bus_rdy=1; DONE->IDLE when biu_cyc_i=0; bus_rdy=0 in all other states.
REQ-025 bus_data driven from the line register only when a read is in XFER/DONE (latched we=0); high-Z otherwise.
REQ-026 Request inputs and freeze changing during XFER have no effect; freeze never aborts a transfer.
REQ-027 A request held continuously through DONE does not retrigger; a new request needs biu_cyc_i low for at least one cycle.

Reset
REQ-028 Reset at any time, including mid-transfer:
- State -> IDLE; beat counter -> 0.
- REQ, WRB, BURST, ADDR, WDATA, BSTROBE, biu_dat_o, bus_rdy, line register -> 0.
- bus_data released (high-Z).

Configuration
REQ-029 Macro ROUTER_WRAP_BURST_EN.
- Defined: line mode uses BURST=10 (WRAP), starting at critical word adr[4:2] and wrapping modulo 32 bytes within the line; the data word index follows the address.
- Undefined: INCR behaviour of REQ-018.

Verification
REQ-030 Line read at 0x0000_1044, cab=1, periph=0, RDATA=beat+0xA0, no stall:
- ADDR 0x1040..0x105C, BURST=01.
- bus_rdy high after 8 ACKs; bus_data word k = 0xA0+k.
REQ-031 Line write, bus_data words = k, with STALL=1 for 2 cycles at beat 3:
- ADDR/WDATA hold during the stall.
- WRB=1; WDATA sequence 0..7.
REQ-032 Peripheral read at 0x4000_0008, sel=4'b0011, RDATA=0x1234_5678:
- BURST=00, BSTROBE=0011.
- biu_dat_o=0x1234_5678; bus_rdy one beat later.
REQ-033 Request with freeze=1:
- REQ stays 0 while freeze=1.
- REQ rises the cycle after freeze drops.
REQ-034 Reset asserted at beat 4 of a line read:
- Immediately REQ=0, bus_rdy=0, bus_data high-Z.
- After release, a fresh request restarts at beat 0.
REQ-035 ROUTER_WRAP_BURST_EN defined, line read at 0x1058:
- BURST=10.
- ADDR sequence 0x1058, 0x105C, 0x1040, ..., 0x1054.
